// File: rtl/hazard_stall_ctrl.sv
// Hazard sequencer: load-use stalls, taken-branch flushes and multi-cycle EX waits for the 5-stage core.
// Optional HAZARD_PERF_CNT_EN adds saturating StallCnt/FlushCnt performance counters.
module hazard_stall_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [4:0] IFIDrs,
  input  logic [4:0] IFIDrt,
  input  logic       IFIDUsesRt,
  input  logic [4:0] IDEXrt,
  input  logic       IDEXMemRead,
  input  logic       BranchTaken,
  input  logic       MulStart,
  input  logic       MulDone,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IFIDFlush,
  output logic       IDEXBubble,
  output logic       ExHold,
  output logic [1:0] State
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    LSTALL = 2'b01,
    FLUSH  = 2'b10,
    MWAIT  = 2'b11
  } state_e;

  localparam logic [2:0] LoadReload  = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FlushReload = 3'(FLUSH_CYCLES - 1);
  localparam bit         LoadMulti   = (LOAD_STALL_CYCLES > 1);
  localparam bit         FlushMulti  = (FLUSH_CYCLES > 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic load_use;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold;

  // rt only matters when the ID instruction actually reads it; $zero never hazards
  assign load_use = IDEXMemRead && (IDEXrt != 5'd0) &&
                    ((IDEXrt == IFIDrs) || (IFIDUsesRt && (IDEXrt == IFIDrt)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    ex_hold     = 1'b0;

    case (state_q)
      MWAIT: begin
        if (MulDone) begin
          state_d = RUN;
        end else begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          ex_hold    = 1'b1;
        end
      end

      default: begin
        // A taken branch pre-empts any stall or flush in progress and restarts the flush
        if (BranchTaken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (FlushMulti) begin
            state_d = FLUSH;
            cnt_d   = FlushReload;
          end else begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end
        end else if (state_q == LSTALL) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          cnt_d       = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end
        end else if (state_q == FLUSH) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          cnt_d       = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end
        end else if (MulStart) begin
          state_d = MWAIT;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (LoadMulti) begin
            state_d = LSTALL;
            cnt_d   = LoadReload;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset overrides asynchronously so an in-flight stall or wait is dropped at once
  assign PCWrite    = Rst ? 1'b0 : pc_write;
  assign IFIDWrite  = Rst ? 1'b0 : ifid_write;
  assign IFIDFlush  = Rst ? 1'b1 : ifid_flush;
  assign IDEXBubble = Rst ? 1'b1 : idex_bubble;
  assign ExHold     = Rst ? 1'b0 : ex_hold;
  assign State      = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (!pc_write && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (ifid_flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three parameterisations driven in parallel, directed scenarios
// plus randomized stimulus against a cycles-remaining reference model.
module tb_hazard_stall_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [4:0] IFIDrs = '0, IFIDrt = '0, IDEXrt = '0;
  logic       IFIDUsesRt = 1'b0, IDEXMemRead = 1'b0;
  logic       BranchTaken = 1'b0, MulStart = 1'b0, MulDone = 1'b0;

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, ExHold, State[1:0]}
  logic [2:0][6:0] obs;
`ifdef HAZARD_PERF_CNT_EN
  logic [2:0][15:0] scnt, fcnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  // Configs (LOAD_STALL_CYCLES, FLUSH_CYCLES): dut0=(1,1) dut1=(2,3) dut2=(3,2)
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       pcw, ifw, fl, bub, hold;
    logic [1:0] st;
    hazard_stall_ctrl #(
      .LOAD_STALL_CYCLES(g + 1),
      .FLUSH_CYCLES     ((g == 1) ? 3 : ((g == 2) ? 2 : 1))
    ) u_dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .IFIDrs     (IFIDrs),
      .IFIDrt     (IFIDrt),
      .IFIDUsesRt (IFIDUsesRt),
      .IDEXrt     (IDEXrt),
      .IDEXMemRead(IDEXMemRead),
      .BranchTaken(BranchTaken),
      .MulStart   (MulStart),
      .MulDone    (MulDone),
      .PCWrite    (pcw),
      .IFIDWrite  (ifw),
      .IFIDFlush  (fl),
      .IDEXBubble (bub),
      .ExHold     (hold),
      .State      (st)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .StallCnt   (scnt[g]),
      .FlushCnt   (fcnt[g])
`endif
    );
    assign obs[g] = {pcw, ifw, fl, bub, hold, st};
  end

  // Reference model: counts of remaining stall/flush cycles and a multiply-busy flag
  int lsc [3] = '{1, 2, 3};
  int fc  [3] = '{1, 3, 2};
  int stall_left [3] = '{0, 0, 0};
  int flush_left [3] = '{0, 0, 0};
  bit mul_busy   [3] = '{0, 0, 0};
  int m_scnt     [3] = '{0, 0, 0};
  int m_fcnt     [3] = '{0, 0, 0};

  function automatic bit load_use();
    return IDEXMemRead && (IDEXrt != 0) &&
           ((IDEXrt == IFIDrs) || (IFIDUsesRt && (IDEXrt == IFIDrt)));
  endfunction

  function automatic logic [6:0] exp_vec(int k);
    logic [1:0] st;
    logic [4:0] o;
    if (Rst) return 7'b0011000;
    st = mul_busy[k] ? 2'd3 : (stall_left[k] > 0) ? 2'd1 : (flush_left[k] > 0) ? 2'd2 : 2'd0;
    if (mul_busy[k])                             o = MulDone ? 5'b11000 : 5'b00001;
    else if (BranchTaken || flush_left[k] > 0)   o = 5'b11110;
    else if (stall_left[k] > 0)                  o = 5'b00010;
    else if (!MulStart && load_use())            o = 5'b00010;
    else                                         o = 5'b11000;
    return {o, st};
  endfunction

  always @(posedge Clk or posedge Rst) begin
    for (int k = 0; k < 3; k++) begin
      automatic logic [6:0] e = exp_vec(k);
      if (Rst) begin
        stall_left[k] <= 0;
        flush_left[k] <= 0;
        mul_busy[k]   <= 1'b0;
        m_scnt[k]     <= 0;
        m_fcnt[k]     <= 0;
      end else begin
        if (!e[6] && m_scnt[k] < 65535) m_scnt[k] <= m_scnt[k] + 1;
        if (e[4] && m_fcnt[k] < 65535)  m_fcnt[k] <= m_fcnt[k] + 1;
        if (mul_busy[k]) begin
          if (MulDone) mul_busy[k] <= 1'b0;
        end else if (BranchTaken) begin
          flush_left[k] <= fc[k] - 1;
          stall_left[k] <= 0;
        end else if (stall_left[k] > 0) begin
          stall_left[k] <= stall_left[k] - 1;
        end else if (flush_left[k] > 0) begin
          flush_left[k] <= flush_left[k] - 1;
        end else if (MulStart) begin
          mul_busy[k] <= 1'b1;
        end else if (load_use()) begin
          stall_left[k] <= lsc[k] - 1;
        end
      end
    end
  end

  logic [6:0] trace [3][8];

  task automatic idle();
    IFIDrs = '0; IFIDrt = '0; IDEXrt = '0; IFIDUsesRt = 1'b0; IDEXMemRead = 1'b0;
    BranchTaken = 1'b0; MulStart = 1'b0; MulDone = 1'b0;
  endtask

  task automatic record(input int idx);
    #1;
    for (int k = 0; k < 3; k++) trace[k][idx] = obs[k];
  endtask

  // One cycle of load with the given registers, then idle; returns PCWrite-low cycle counts
  task automatic run_hazard(input logic [4:0] ex_rt, input logic [4:0] rs, input logic [4:0] rt,
                            input logic uses, output int cnt [3]);
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    @(negedge Clk);
    idle();
    IDEXMemRead = 1'b1; IDEXrt = ex_rt; IFIDrs = rs; IFIDrt = rt; IFIDUsesRt = uses;
    record(0);
    for (int c = 1; c < 6; c++) begin
      @(negedge Clk);
      idle();
      record(c);
    end
    for (int c = 0; c < 6; c++)
      for (int k = 0; k < 3; k++) if (!trace[k][c][6]) cnt[k]++;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== 7'b0011000) begin
        failures++;
        $display("FAIL reset_hold dut%0d: got %b expected %b", k, obs[k], 7'b0011000);
      end
    end
    @(negedge Clk);
    Rst = 1'b0;
    idle();
    record(0);
    @(negedge Clk);
    record(1);
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 2; c++) begin
        checks++;
        if (trace[k][c] !== 7'b1100000) begin
          failures++;
          $display("FAIL reset_release dut%0d cyc%0d: got %b expected %b", k, c, trace[k][c], 7'b1100000);
        end
      end
  endtask

  task automatic test_load_use();
    int cnt [3];
    run_hazard(5'd5, 5'd5, 5'd0, 1'b0, cnt);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cnt[k] !== lsc[k]) begin
        failures++;
        $display("FAIL load_use_len dut%0d: got %0d stall cycles expected %0d", k, cnt[k], lsc[k]);
      end
    end
    checks++;
    if (trace[1][0] !== 7'b0001000 || trace[1][1] !== 7'b0001001 || trace[1][2] !== 7'b1100000) begin
      failures++;
      $display("FAIL load_use_seq dut1: got %b %b %b expected 0001000 0001001 1100000",
               trace[1][0], trace[1][1], trace[1][2]);
    end
    run_hazard(5'd0, 5'd0, 5'd0, 1'b0, cnt);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cnt[k] !== 0) begin
        failures++;
        $display("FAIL load_use_r0 dut%0d: got %0d stall cycles expected 0", k, cnt[k]);
      end
    end
  endtask

  task automatic test_rt_check();
    int cnt [3];
    run_hazard(5'd7, 5'd3, 5'd7, 1'b0, cnt);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cnt[k] !== 0) begin
        failures++;
        $display("FAIL rt_unused dut%0d: got %0d stall cycles expected 0", k, cnt[k]);
      end
    end
    run_hazard(5'd7, 5'd3, 5'd7, 1'b1, cnt);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cnt[k] !== lsc[k]) begin
        failures++;
        $display("FAIL rt_used dut%0d: got %0d stall cycles expected %0d", k, cnt[k], lsc[k]);
      end
    end
  endtask

  task automatic test_branch_in_stall();
    logic [6:0] exp_t [3][5];
    exp_t[0] = '{7'b0001000, 7'b1111000, 7'b1100000, 7'b1100000, 7'b1100000};
    exp_t[1] = '{7'b0001000, 7'b1111001, 7'b1111010, 7'b1111010, 7'b1100000};
    exp_t[2] = '{7'b0001000, 7'b1111001, 7'b1111010, 7'b1100000, 7'b1100000};
    @(negedge Clk);
    idle();
    IDEXMemRead = 1'b1; IDEXrt = 5'd9; IFIDrs = 5'd9;
    record(0);
    @(negedge Clk);
    idle();
    BranchTaken = 1'b1;
    record(1);
    for (int c = 2; c < 5; c++) begin
      @(negedge Clk);
      idle();
      record(c);
    end
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 5; c++) begin
        checks++;
        if (trace[k][c] !== exp_t[k][c]) begin
          failures++;
          $display("FAIL branch_in_stall dut%0d cyc%0d: got %b expected %b", k, c, trace[k][c], exp_t[k][c]);
        end
      end
  endtask

  task automatic test_mul();
    logic [6:0] exp_m [7] = '{7'b1100000, 7'b0000111, 7'b0000111, 7'b0000111,
                              7'b0000111, 7'b1100011, 7'b1100000};
    @(negedge Clk);
    idle();
    MulStart = 1'b1;
    record(0);
    for (int c = 1; c < 7; c++) begin
      @(negedge Clk);
      idle();
      BranchTaken = (c == 2);
      MulDone     = (c == 5);
      record(c);
    end
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 7; c++) begin
        checks++;
        if (trace[k][c] !== exp_m[c]) begin
          failures++;
          $display("FAIL mul_wait dut%0d cyc%0d: got %b expected %b", k, c, trace[k][c], exp_m[c]);
        end
      end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_b [4] = '{7'b1100000, 7'b0000111, 7'b1100011, 7'b1100000};
    @(negedge Clk);
    idle();
    MulStart = 1'b1; MulDone = 1'b1;
    record(0);
    for (int c = 1; c < 4; c++) begin
      @(negedge Clk);
      idle();
      MulDone = (c == 2);
      record(c);
    end
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (trace[k][c] !== exp_b[c]) begin
          failures++;
          $display("FAIL start_done_same dut%0d cyc%0d: got %b expected %b", k, c, trace[k][c], exp_b[c]);
        end
      end
  endtask

  task automatic test_async_reset();
    @(negedge Clk);
    idle();
    MulStart = 1'b1;
    @(negedge Clk);
    idle();
    @(negedge Clk);
    @(posedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== 7'b0011000) begin
        failures++;
        $display("FAIL async_reset dut%0d: got %b expected %b", k, obs[k], 7'b0011000);
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (scnt[k] !== 16'd0 || fcnt[k] !== 16'd0) begin
        failures++;
        $display("FAIL async_reset_perf dut%0d: got stall=%0d flush=%0d expected 0 0", k, scnt[k], fcnt[k]);
      end
`endif
    end
    @(negedge Clk);
    Rst = 1'b0;
    record(0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (trace[k][0] !== 7'b1100000) begin
        failures++;
        $display("FAIL async_reset_abort dut%0d: got %b expected %b", k, trace[k][0], 7'b1100000);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge Clk);
      Rst         = ($urandom_range(0, 79) == 0);
      IFIDrs      = 5'($urandom_range(0, 3));
      IFIDrt      = 5'($urandom_range(0, 3));
      IDEXrt      = 5'($urandom_range(0, 3));
      IFIDUsesRt  = $urandom_range(0, 1) == 1;
      IDEXMemRead = $urandom_range(0, 1) == 1;
      BranchTaken = ($urandom_range(0, 7) == 0);
      MulStart    = ($urandom_range(0, 9) == 0);
      MulDone     = ($urandom_range(0, 3) == 0);
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          failures++;
          $display("FAIL random_outputs dut%0d cyc%0d: got %b expected %b", k, c, obs[k], exp_vec(k));
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (scnt[k] !== 16'(m_scnt[k]) || fcnt[k] !== 16'(m_fcnt[k])) begin
          failures++;
          $display("FAIL random_perf dut%0d cyc%0d: got stall=%0d flush=%0d expected %0d %0d",
                   k, c, scnt[k], fcnt[k], m_scnt[k], m_fcnt[k]);
        end
`endif
      end
    end
    @(negedge Clk);
    Rst = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_rt_check();
    test_branch_in_stall();
    test_mul();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
